// File: rtl/pcie_img_pkg.sv
// Shared constants, quadrant encoding and FSM state type for the PCIe
// image split/merge datapath (host-to-FPGA splitter and quadrant writer).
package pcie_img_pkg;

   localparam int COL_NUM      = 160;           // 128-bit beats per 1280-pixel RGB565 line
   localparam int HALF_COL_NUM = COL_NUM / 2;
   localparam int ROW_NUM      = 720;           // lines per frame
   localparam int HALF_ROW_NUM = ROW_NUM / 2;
   localparam int DATA_W       = 128;
   localparam int VS_LEN       = 16;            // cycles the frame-base update is held
   localparam int CNT_W        = 12;            // position counter width

   // Quadrant index is {bottom, right}
   typedef enum logic [1:0] {
      QUAD_TL = 2'd0,
      QUAD_TR = 2'd1,
      QUAD_BL = 2'd2,
      QUAD_BR = 2'd3
   } quad_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VS     = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Map a 1-based (col,row) position to its quadrant; the left/top halves
   // include the half-way column/row.
   function automatic logic [1:0] quad_sel(input logic [CNT_W-1:0] col,
                                           input logic [CNT_W-1:0] row,
                                           input logic [CNT_W-1:0] half_col,
                                           input logic [CNT_W-1:0] half_row);
      logic right_s;
      logic bottom_s;
      right_s  = (col > half_col);
      bottom_s = (row > half_row);
      return {bottom_s, right_s};
   endfunction

endpackage

// File: rtl/pcie_frame_pos_cnt.sv
// 1-based column/row position tracker for a raster of COLS x ROWS beats.
// Reports the quadrant of the current position and whether it is the last
// beat of the frame.
module pcie_frame_pos_cnt
   import pcie_img_pkg::*;
#(
   parameter int COLS = COL_NUM,
   parameter int ROWS = ROW_NUM
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   output logic [CNT_W-1:0] col_cnt,
   output logic [CNT_W-1:0] row_cnt,
   output logic [1:0]       q,
   output logic             last_beat
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS);
   localparam logic [CNT_W-1:0] COL_HALF = CNT_W'(COLS / 2);
   localparam logic [CNT_W-1:0] ROW_HALF = CNT_W'(ROWS / 2);

   logic [CNT_W-1:0] col_cnt_r;
   logic [CNT_W-1:0] row_cnt_r;

   // Position counters: clear dominates, otherwise step one beat in raster order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_cnt_r <= CNT_ONE;
         row_cnt_r <= CNT_ONE;
      end else if (clear) begin
         col_cnt_r <= CNT_ONE;
         row_cnt_r <= CNT_ONE;
      end else if (advance) begin
         if (col_cnt_r == COL_LAST) begin
            col_cnt_r <= CNT_ONE;
            if (row_cnt_r == ROW_LAST) begin
               row_cnt_r <= CNT_ONE;
            end else begin
               row_cnt_r <= row_cnt_r + CNT_ONE;
            end
         end else begin
            col_cnt_r <= col_cnt_r + CNT_ONE;
         end
      end else begin
         col_cnt_r <= col_cnt_r;
         row_cnt_r <= row_cnt_r;
      end
   end

   assign col_cnt   = col_cnt_r;
   assign row_cnt   = row_cnt_r;
   assign q         = quad_sel(col_cnt_r, row_cnt_r, COL_HALF, ROW_HALF);
   assign last_beat = (col_cnt_r == COL_LAST) && (row_cnt_r == ROW_LAST);

endmodule

// File: rtl/pcie_img_split.sv
// Host-to-FPGA frame splitter: takes the DMA read-beat stream of one frame
// and steers each beat to the write port of the quadrant it belongs to.
// A full target channel stalls the whole stream so frame order is kept.
module pcie_img_split
   import pcie_img_pkg::*;
#(
   parameter int COLS = COL_NUM,
   parameter int ROWS = ROW_NUM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dma_frame_start,
   input  logic              dma_rd_valid,
   input  logic [DATA_W-1:0] dma_rd_data,
   output logic              dma_rd_ready,
   input  logic [3:0]        ch_wr_full,
   output logic              ch0_wr_en,
   output logic              ch1_wr_en,
   output logic              ch2_wr_en,
   output logic              ch3_wr_en,
   output logic [DATA_W-1:0] ch0_wr_data,
   output logic [DATA_W-1:0] ch1_wr_data,
   output logic [DATA_W-1:0] ch2_wr_data,
   output logic [DATA_W-1:0] ch3_wr_data,
   output logic              ch_frame_vs,
   output logic              frame_done,
   output logic              frame_err
);

   localparam int          VS_W    = $clog2(VS_LEN);
   localparam logic [VS_W-1:0] VS_LAST = VS_W'(VS_LEN - 1);

   state_e              state_r;
   state_e              state_next_s;
   logic [VS_W-1:0]     vs_cnt_r;
   logic [CNT_W-1:0]    col_cnt_s;
   logic [CNT_W-1:0]    row_cnt_s;
   logic [2*CNT_W-1:0]  pos_unused_s;
   logic [1:0]          q_s;
   logic                last_beat_s;
   logic                ready_s;
   logic                accept_s;
   logic                clear_s;
   logic [3:0]          wr_en_next_s;
   logic [3:0]          wr_en_r;
   logic [DATA_W-1:0]   wr_data_r [4];
   logic                ch_frame_vs_r;
   logic                frame_done_r;
   logic                frame_err_r;

   pcie_frame_pos_cnt #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_pos (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear_s),
      .advance   (accept_s),
      .col_cnt   (col_cnt_s),
      .row_cnt   (row_cnt_s),
      .q         (q_s),
      .last_beat (last_beat_s)
   );

   // Raw position is only needed inside the counter; quadrant/last cover us.
   assign pos_unused_s = {row_cnt_s, col_cnt_s};

   // A new frame start always wins over a pending beat so an aborted frame
   // never leaks a beat into the next one.
   assign ready_s      = (state_r == ST_ACTIVE) && !ch_wr_full[q_s] && !dma_frame_start;
   assign accept_s     = dma_rd_valid && ready_s;
   assign clear_s      = (state_next_s == ST_VS);
   assign dma_rd_ready = ready_s;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; a frame start from any state (re)enters VS.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (dma_frame_start) begin
               state_next_s = ST_VS;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_VS: begin
            if (dma_frame_start) begin
               state_next_s = ST_VS;
            end else if (vs_cnt_r == VS_LAST) begin
               state_next_s = ST_ACTIVE;
            end else begin
               state_next_s = ST_VS;
            end
         end
         ST_ACTIVE: begin
            if (dma_frame_start) begin
               state_next_s = ST_VS;
            end else if (accept_s && last_beat_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_ACTIVE;
            end
         end
         ST_DONE: begin
            if (dma_frame_start) begin
               state_next_s = ST_VS;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // VS duration counter; restarts on every frame start seen during VS.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_cnt_r <= {VS_W{1'b0}};
      end else if ((state_r == ST_VS) && !dma_frame_start) begin
         vs_cnt_r <= vs_cnt_r + VS_W'(1);
      end else begin
         vs_cnt_r <= {VS_W{1'b0}};
      end
   end

   // One-hot strobe for the quadrant of the accepted beat.
   always_comb begin
      wr_en_next_s = 4'b0000;
      if (accept_s) begin
         wr_en_next_s[q_s] = 1'b1;
      end else begin
         wr_en_next_s = 4'b0000;
      end
   end

   // Registered strobes and frame status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_r       <= 4'b0000;
         ch_frame_vs_r <= 1'b0;
         frame_done_r  <= 1'b0;
         frame_err_r   <= 1'b0;
      end else begin
         wr_en_r       <= wr_en_next_s;
         ch_frame_vs_r <= (state_next_s == ST_VS);
         frame_done_r  <= (state_next_s == ST_DONE);
         frame_err_r   <= (state_r == ST_ACTIVE) && dma_frame_start;
      end
   end

   // Per-channel write data: load the accepted beat, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int n = 0; n < 4; n++) begin
            wr_data_r[n] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (accept_s && (q_s == 2'(n))) begin
               wr_data_r[n] <= dma_rd_data;
            end else begin
               wr_data_r[n] <= wr_data_r[n];
            end
         end
      end
   end

   assign ch0_wr_en   = wr_en_r[0];
   assign ch1_wr_en   = wr_en_r[1];
   assign ch2_wr_en   = wr_en_r[2];
   assign ch3_wr_en   = wr_en_r[3];
   assign ch0_wr_data = wr_data_r[0];
   assign ch1_wr_data = wr_data_r[1];
   assign ch2_wr_data = wr_data_r[2];
   assign ch3_wr_data = wr_data_r[3];
   assign ch_frame_vs = ch_frame_vs_r;
   assign frame_done  = frame_done_r;
   assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_pcie_img_split.sv
// Scoreboard bench for pcie_img_split on a reduced 16x12-beat frame.
// The driver pushes the expected (channel, data, last) of each accepted
// beat; the monitor pops and compares on every write strobe.
module tb_pcie_img_split;
   import pcie_img_pkg::*;

   localparam int COLS  = 16;
   localparam int ROWS  = 12;
   localparam int BEATS = COLS * ROWS;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              dma_frame_start;
   logic              dma_rd_valid;
   logic [DATA_W-1:0] dma_rd_data;
   logic              dma_rd_ready;
   logic [3:0]        ch_wr_full;
   logic              ch0_wr_en, ch1_wr_en, ch2_wr_en, ch3_wr_en;
   logic [DATA_W-1:0] ch0_wr_data, ch1_wr_data, ch2_wr_data, ch3_wr_data;
   logic              ch_frame_vs;
   logic              frame_done;
   logic              frame_err;

   typedef struct {
      int                ch;
      logic [DATA_W-1:0] data;
      bit                last;
      int                idx;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ch_cnt[4];
   int   done_cnt;
   int   obs_ch[BEATS];
   int   model_idx = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   pcie_img_split #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dma_frame_start (dma_frame_start),
      .dma_rd_valid    (dma_rd_valid),
      .dma_rd_data     (dma_rd_data),
      .dma_rd_ready    (dma_rd_ready),
      .ch_wr_full      (ch_wr_full),
      .ch0_wr_en       (ch0_wr_en),
      .ch1_wr_en       (ch1_wr_en),
      .ch2_wr_en       (ch2_wr_en),
      .ch3_wr_en       (ch3_wr_en),
      .ch0_wr_data     (ch0_wr_data),
      .ch1_wr_data     (ch1_wr_data),
      .ch2_wr_data     (ch2_wr_data),
      .ch3_wr_data     (ch3_wr_data),
      .ch_frame_vs     (ch_frame_vs),
      .frame_done      (frame_done),
      .frame_err       (frame_err)
   );

   // Reference quadrant of the idx-th beat (0-based) of a raster frame.
   function automatic int exp_ch(input int idx);
      int row;
      int col;
      row = idx / COLS;
      col = idx % COLS;
      return ((row >= ROWS / 2) ? 2 : 0) + ((col >= COLS / 2) ? 1 : 0);
   endfunction

   function automatic logic [DATA_W-1:0] rand_beat();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_d(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      for (int n = 0; n < 4; n++) ch_cnt[n] = 0;
      done_cnt = 0;
      for (int i = 0; i < BEATS; i++) obs_ch[i] = -1;
   endtask

   task automatic check_all_zero(input string tag);
      check_v({tag, "_ready"}, 32'(dma_rd_ready), 32'd0);
      check_v({tag, "_wr_en"}, 32'({ch3_wr_en, ch2_wr_en, ch1_wr_en, ch0_wr_en}), 32'd0);
      check_d({tag, "_data0"}, ch0_wr_data, {DATA_W{1'b0}});
      check_d({tag, "_data1"}, ch1_wr_data, {DATA_W{1'b0}});
      check_d({tag, "_data2"}, ch2_wr_data, {DATA_W{1'b0}});
      check_d({tag, "_data3"}, ch3_wr_data, {DATA_W{1'b0}});
      check_v({tag, "_vs"}, 32'(ch_frame_vs), 32'd0);
      check_v({tag, "_done"}, 32'(frame_done), 32'd0);
      check_v({tag, "_err"}, 32'(frame_err), 32'd0);
   endtask

   // One-cycle frame start with a beat offered that must not be taken.
   task automatic pulse_start();
      dma_frame_start = 1'b1;
      dma_rd_valid    = 1'b1;
      dma_rd_data     = rand_beat();
      #1;
      check_v("ready_on_start", 32'(dma_rd_ready), 32'd0);
      step();
      dma_frame_start = 1'b0;
   endtask

   // Start a frame and check the VS window; optionally restart VS part-way.
   task automatic do_start(input bit exp_err, input int restart_at);
      ch_wr_full = 4'b0000;
      model_idx  = 0;
      pulse_start();
      check_v("frame_err_pulse", 32'(frame_err), 32'(exp_err));
      check_v("vs_rise", 32'(ch_frame_vs), 32'd1);
      if (restart_at > 0) begin
         for (int k = 1; k < restart_at; k++) begin
            step();
            check_v("vs_before_restart", 32'(ch_frame_vs), 32'd1);
         end
         pulse_start();
         check_v("frame_err_vs_restart", 32'(frame_err), 32'd0);
         check_v("vs_after_restart", 32'(ch_frame_vs), 32'd1);
      end
      for (int k = 1; k < VS_LEN; k++) begin
         step();
         check_v("vs_high", 32'(ch_frame_vs), 32'd1);
         check_v("ready_in_vs", 32'(dma_rd_ready), 32'd0);
         check_v("frame_err_low", 32'(frame_err), 32'd0);
      end
      step();
      check_v("vs_fall", 32'(ch_frame_vs), 32'd0);
      check_v("ready_after_vs", 32'(dma_rd_ready), 32'd1);
   endtask

   // Offer n beats of the current frame; rv randomises valid, bp adds backpressure.
   task automatic send_beats(input int n, input bit rv, input bit bp);
      int                forced;
      bit                forced_done;
      bit                acc;
      int                tries;
      logic [DATA_W-1:0] d;
      forced      = 0;
      forced_done = 1'b0;
      for (int b = 0; b < n; b++) begin
         d     = rand_beat();
         acc   = 1'b0;
         tries = 0;
         while (!acc) begin
            if (bp && !forced_done && ((model_idx % COLS) == COLS / 2)) begin
               forced      = 3;
               forced_done = 1'b1;
            end
            if (forced > 0) begin
               ch_wr_full = 4'b0010;
               forced--;
            end else if (bp && ($urandom_range(0, 3) == 0)) begin
               ch_wr_full = 4'($urandom_range(1, 15));
            end else begin
               ch_wr_full = 4'b0000;
            end
            dma_rd_valid = rv ? ($urandom_range(0, 4) != 0) : 1'b1;
            dma_rd_data  = d;
            #1;
            check_v("rd_ready", 32'(dma_rd_ready), 32'(!ch_wr_full[exp_ch(model_idx)]));
            acc = dma_rd_valid && dma_rd_ready;
            if (acc) begin
               sb_q.push_back('{exp_ch(model_idx), d, (model_idx == BEATS - 1), model_idx});
               model_idx++;
            end
            tries++;
            step();
            if (!acc && (tries >= 64)) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout actual=no_accept required=accept beat=%0d", model_idx);
               dma_rd_valid = 1'b0;
               ch_wr_full   = 4'b0000;
               return;
            end
         end
      end
      dma_rd_valid = 1'b0;
      ch_wr_full   = 4'b0000;
   endtask

   task automatic frame_check();
      for (int n = 0; n < 4; n++) check_v("quadrant_strobe_count", 32'(ch_cnt[n]), 32'(BEATS / 4));
      check_v("frame_done_count", 32'(done_cnt), 32'd1);
      check_v("first_beat_ch0", 32'(obs_ch[0]), 32'd0);
      check_v("first_right_beat_ch1", 32'(obs_ch[COLS / 2]), 32'd1);
      check_v("mid_line_end_ch1", 32'(obs_ch[(ROWS / 2) * COLS - 1]), 32'd1);
      check_v("mid_line_next_ch2", 32'(obs_ch[(ROWS / 2) * COLS]), 32'd2);
      check_v("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      clear_stats();
   endtask

   // Monitor: every strobe must match the oldest expected beat.
   always @(negedge clk) begin : monitor
      logic [3:0]        en_v;
      int                ch;
      logic [DATA_W-1:0] d;
      exp_t              e;
      if (mon_en) begin
         en_v = {ch3_wr_en, ch2_wr_en, ch1_wr_en, ch0_wr_en};
         if (frame_done === 1'b1) done_cnt++;
         if (en_v != 4'b0000) begin
            check_v("strobe_onehot", 32'($countones(en_v)), 32'd1);
            ch = 0;
            for (int n = 3; n >= 0; n--) if (en_v[n]) ch = n;
            case (ch)
               0:       d = ch0_wr_data;
               1:       d = ch1_wr_data;
               2:       d = ch2_wr_data;
               default: d = ch3_wr_data;
            endcase
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe actual=ch%0d required=none t=%0t", ch, $time);
            end else begin
               e = sb_q.pop_front();
               check_v("strobe_channel", 32'(ch), 32'(e.ch));
               check_d("strobe_data", d, e.data);
               check_v("frame_done_with_last", 32'(frame_done), 32'(e.last));
               ch_cnt[ch]++;
               obs_ch[e.idx] = ch;
            end
         end else begin
            check_v("frame_done_idle", 32'(frame_done), 32'd0);
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      dma_frame_start = 1'b0;
      dma_rd_valid    = 1'b0;
      dma_rd_data     = {DATA_W{1'b0}};
      ch_wr_full      = 4'b0000;
      clear_stats();
      repeat (3) step();
      check_all_zero("reset");
      mon_en = 1'b1;
      rst_n  = 1'b1;

      // Beats offered before any frame start are held off.
      dma_rd_valid = 1'b1;
      dma_rd_data  = rand_beat();
      for (int k = 0; k < 5; k++) begin
         #1;
         check_v("idle_guard_ready", 32'(dma_rd_ready), 32'd0);
         step();
      end

      // Back-to-back frame, then DONE falls back to IDLE.
      do_start(1'b0, 0);
      send_beats(BEATS, 1'b0, 1'b0);
      frame_check();
      dma_rd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_v("post_done_ready", 32'(dma_rd_ready), 32'd0);
      end

      // VS restart, random valid and backpressure.
      do_start(1'b0, 5);
      send_beats(BEATS, 1'b1, 1'b1);
      frame_check();

      // Start straight out of DONE, then abort part-way through.
      do_start(1'b0, 0);
      send_beats(100, 1'b1, 1'b1);
      clear_stats();
      do_start(1'b1, 0);
      send_beats(BEATS, 1'b1, 1'b1);
      frame_check();

      // Reset part-way through a frame.
      step();
      do_start(1'b0, 0);
      send_beats(50, 1'b1, 1'b1);
      rst_n        = 1'b0;
      dma_rd_valid = 1'b0;
      step();
      check_all_zero("mid_reset");
      rst_n        = 1'b1;
      dma_rd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_v("after_reset_ready", 32'(dma_rd_ready), 32'd0);
         step();
      end
      check_v("after_reset_sb_empty", 32'(sb_q.size()), 32'd0);
      clear_stats();
      do_start(1'b0, 0);
      send_beats(BEATS, 1'b0, 1'b1);
      frame_check();

      repeat (4) step();
      check_v("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_img_split.md
# pcie_img_split

Host-to-FPGA counterpart of the quadrant DMA writer. It accepts a 1280x720 RGB565 frame streamed by the PCIe DMA read engine as 128-bit beats. It tracks column and row position and steers each beat to one of four quadrant channel write ports (ch0 top-left, ch1 top-right, ch2 bottom-left, ch3 bottom-right). It also issues the frame-start pulse that rebases the channel frame buffers. It sits between the PCIe DMA read-data interface and the four DDR channel write FIFOs.

## Interface
- COL_NUM, 160: beats per line (1280*16/128).
- ROW_NUM, 720: lines per frame.
- DATA_W, 128: beat width.
- VS_LEN, 16: cycles `ch_frame_vs` is held high per frame.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- dma_frame_start  in  1  one-cycle pulse: host has started a new frame transfer.
- dma_rd_valid  in  1  `dma_rd_data` holds a valid beat.
- dma_rd_data  in  DATA_W  beat from the DMA read engine.
- dma_rd_ready  out  1  block accepts a beat this cycle.
- ch_wr_full  in  4  per-channel almost-full; bit n belongs to channel n.
- ch0_wr_en .. ch3_wr_en  out  1  write strobe to channel n.
- ch0_wr_data .. ch3_wr_data  out  DATA_W  write data to channel n.
- ch_frame_vs  out  1  frame-base update to all four channel writers.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is written.
- frame_err  out  1  one-cycle pulse when a frame is aborted by a new `dma_frame_start`.

## Operation
- Reset: every output is 0, FSM is in IDLE, `col_cnt`=1, `row_cnt`=1, VS counter is 0.
- FSM states: IDLE, VS, ACTIVE, DONE.
  - IDLE -> VS on `dma_frame_start`.
  - VS: `ch_frame_vs`=1 for VS_LEN cycles, then -> ACTIVE. A `dma_frame_start` during VS restarts the VS count with no error.
  - ACTIVE -> DONE on acceptance of the beat with `col_cnt`=COL_NUM and `row_cnt`=ROW_NUM.
  - ACTIVE -> VS on `dma_frame_start`: `frame_err` pulses, counters return to 1, and any beat offered that cycle is not accepted.
  - DONE: `frame_done`=1 for one cycle, then -> IDLE. A `dma_frame_start` in DONE -> VS with no error.
- Position counters are 1-based, 12 bits, and advance only on an accepted beat.
  - `col_cnt` wraps from COL_NUM to 1 and increments `row_cnt`.
  - `row_cnt` wraps from ROW_NUM to 1.
  - Both counters load 1 on entry to VS.
- Quadrant selection uses the current counters. Left half: `col_cnt` <= COL_NUM/2. Top half: `row_cnt` <= ROW_NUM/2. The selected channel index is q = {bottom, right}.
- `dma_rd_ready` = (state==ACTIVE) & !ch_wr_full[q] & !dma_frame_start, decoded combinationally from registered state.
- Accept is `dma_rd_valid` & `dma_rd_ready`.
  - On accept, `chq_wr_en` is registered to 1, `chq_wr_data` is registered to the beat, and the other three strobes are 0.
  - Without accept, all strobes are 0.
  - Write-data registers hold their previous value when not written.
- A beat is never dropped or duplicated. A full target channel stalls the whole stream, including beats for other quadrants, so frame order is preserved.

## Timing
- Latency: a beat accepted on edge N has `chq_wr_en` high after edge N+1.
- Throughput: 1 beat per cycle while valid and the target channel is not full.
- `ch_frame_vs` rises 1 cycle after `dma_frame_start` and stays high exactly VS_LEN cycles. The first beat can be accepted on the cycle after it falls.
- `frame_done` goes high 1 cycle after the final beat is accepted, coincident with the final `ch3_wr_en`.
- `ch_wr_full` is treated as almost-full. The channel FIFO must absorb the 1 beat already in the output register.
- Reset asserted mid-frame: all outputs drop to 0 at the next edge. Nothing resumes until a new `dma_frame_start`.
- `dma_rd_valid` while in IDLE, VS or DONE: `dma_rd_ready`=0 and the beat is held off, not discarded.

## Structure
- `pcie_img_pkg` holds the shared constants COL_NUM, HALF_COL_NUM, ROW_NUM and HALF_ROW_NUM, the 2-bit quadrant encoding, and the FSM state enum. The quadrant DMA writer uses the same package.
- One sub-module, `pcie_frame_pos_cnt`, contains the col/row counters with inputs clear and advance, and outputs the counters, q and last_beat. The mirror writer block reuses it.

## Test plan
- Full frame, `dma_rd_valid` held at 1, no full: 115200 beats; ch0/ch1/ch2/ch3 each get 28800 strobes; beat 81 goes to ch1 and beat 57601 goes to ch2; `frame_done` fires once.
- Line boundary: the beat with `col_cnt`=160 and `row_cnt`=360 -> ch1; the next beat -> ch2 with `col_cnt`=1 and `row_cnt`=361.
- Backpressure: `ch_wr_full`=4'b0010 on entry to column 81 -> `dma_rd_ready`=0 until it clears; the output data sequence matches the input with no gaps or duplicates.
- Abort: `dma_frame_start` after 1000 beats -> `frame_err`=1 for 1 cycle and `ch_frame_vs` high for 16 cycles; the next accepted beat goes to ch0 at position (1,1).
- Idle guard: `dma_rd_valid`=1 before any `dma_frame_start` -> `dma_rd_ready`=0 and no strobes.
- Reset mid-frame: `rst_n`=0 for 1 cycle after 500 beats -> all outputs 0; a new `dma_frame_start` and a full frame complete correctly.
